// File: rtl/score_pkg.sv
// score_pkg: shared types and arithmetic helpers for the whack-a-mole scorer.
// Helpers work on 64-bit values; every width used by score_tracker fits in that.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Width needed to hold multiplier values 1..max_mult.
  function automatic int mult_w(input int max_mult);
    return $clog2(max_mult + 1);
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c = c + {31'b0, v[i]};
    return c;
  endfunction

  // Add, then clamp at lim.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] lim);
    logic [63:0] s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  // Subtract, flooring at zero.
  function automatic logic [63:0] floor_sub(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? (a - b) : 64'd0;
  endfunction

endpackage

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential shift-add-3 converter. A new input value aborts
// any conversion in flight; the result is published W+1 cycles after the
// value last changed. Values above 10^D-1 keep only their low D digits.
module score_bcd_conv #(
  parameter int W = 16,
  parameter int D = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   bin,
  output logic [4*D-1:0] bcd,
  output logic           valid
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   last, sh;
  logic [4*D-1:0] acc, adj, acc_nxt;
  logic [CW-1:0]  cnt;
  logic           unused_msb;

  // One double-dabble step: bias digits >=5, then shift in the next binary bit.
  always_comb begin
    adj = acc;
    for (int d = 0; d < D; d++)
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    acc_nxt = {adj[4*D-2:0], sh[W-1]};
  end

  // Digits shifted out of the top are dropped (low-digit truncation).
  assign unused_msb = adj[4*D-1];

  // Restart on any input change, otherwise step until the count runs out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last  <= '0;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b1;
    end else if (bin != last) begin
      last  <= bin;
      sh    <= bin;
      acc   <= '0;
      cnt   <= CW'(W);
      valid <= 1'b0;
    end else if (cnt != '0) begin
      acc <= acc_nxt;
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        bcd   <= acc_nxt;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_tracker.sv
// score_tracker: round score with streak multiplier, miss penalty, saturation
// and session high score. Optional BCD output when SCORE_BCD_EN is defined.
module score_tracker
  import score_pkg::*;
#(
  parameter  int SCORE_W      = 16,
  parameter  int N_HOLES      = 9,
  parameter  int STREAK_W     = 8,
  parameter  int STREAK_STEP  = 4,
  parameter  int MAX_MULT     = 4,
  parameter  int MISS_PENALTY = 1,
  parameter  int BCD_DIGITS   = 5,
  localparam int MULT_W       = mult_w(MAX_MULT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                time_up,
  input  logic [N_HOLES-1:0]  whacked,
  input  logic                miss,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  high_score,
  output logic [STREAK_W-1:0] streak,
  output logic [MULT_W-1:0]   mult,
  output logic                new_high,
  output logic                game_over
`ifdef SCORE_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] score_bcd,
  output logic                    bcd_valid
`endif
);
  // Arithmetic is carried in 64 bits, wide enough for SCORE_W+MULT_W+clog2(N_HOLES)+1.
  localparam logic [63:0] SMAX = (64'd1 << SCORE_W) - 64'd1;

  state_t              state;
  logic                hit;
  logic [63:0]         pts, s_hit, s_miss, m_raw;
  logic [SCORE_W-1:0]  score_nxt;
  logic [STREAK_W-1:0] streak_nxt;
  logic [MULT_W-1:0]   mult_nxt;

  // Next score/streak/mult for a PLAY cycle: saturating add, then floored penalty.
  always_comb begin
    hit    = |whacked;
    pts    = 64'(popcount(64'(whacked))) * 64'(mult);
    s_hit  = hit  ? sat_add(64'(score), pts, SMAX) : 64'(score);
    s_miss = miss ? floor_sub(s_hit, 64'(MISS_PENALTY)) : s_hit;
    score_nxt = s_miss[SCORE_W-1:0];

    if (miss)                streak_nxt = '0;
    else if (hit && ~&streak) streak_nxt = streak + 1'b1;
    else                     streak_nxt = streak;

    m_raw = 64'd1 + 64'(streak_nxt) / 64'(STREAK_STEP);
    if (m_raw > 64'(MAX_MULT)) m_raw = 64'(MAX_MULT);
    mult_nxt = m_raw[MULT_W-1:0];
  end

  // Round FSM, scoring registers and high-score latch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      score      <= '0;
      high_score <= '0;
      streak     <= '0;
      mult       <= MULT_W'(1);
      new_high   <= 1'b0;
    end else begin
      new_high <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: if (start) begin
          state  <= ST_PLAY;
          score  <= '0;
          streak <= '0;
          mult   <= MULT_W'(1);
        end
        ST_PLAY: begin
          score  <= score_nxt;
          streak <= streak_nxt;
          mult   <= mult_nxt;
          if (time_up) state <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_OVER;
          if (score > high_score) begin
            high_score <= score;
            new_high   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_over = (state == ST_OVER);

`ifdef SCORE_BCD_EN
  score_bcd_conv #(.W(SCORE_W), .D(BCD_DIGITS)) u_bcd (
    .clock (clock),
    .reset (reset),
    .bin   (score),
    .bcd   (score_bcd),
    .valid (bcd_valid)
  );
  logic unused_bits;
  assign unused_bits = ^{s_miss[63:SCORE_W], m_raw[63:MULT_W]};
`else
  logic unused_bits;
  assign unused_bits = ^{s_miss[63:SCORE_W], m_raw[63:MULT_W], (BCD_DIGITS > 0)};
`endif

endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised successor to the single-counter scorer for the whack-a-mole game. Tracks one round's score from a per-hole hit vector, applies a streak-based multiplier and a miss penalty, saturates instead of wrapping, and keeps a session high score across rounds. Sits between the hole/mole controller (hit and miss pulses) and the display driver.

## Interface
- `SCORE_W`, 16: score and high-score width.
- `N_HOLES`, 9: width of the hit vector.
- `STREAK_W`, 8: streak counter width, saturating.
- `STREAK_STEP`, 4: consecutive hit cycles per multiplier step.
- `MAX_MULT`, 4: multiplier ceiling, ≥1.
- `MISS_PENALTY`, 1: points subtracted per miss cycle.
- `BCD_DIGITS`, 5: BCD digit count, used only with `SCORE_BCD_EN`.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low. Clears all state, including high score.
- `start` in 1: start a round. Honoured in IDLE and OVER only.
- `time_up` in 1: round timer expired. Honoured in PLAY only.
- `whacked` in N_HOLES: one bit per hole hit this cycle.
- `miss` in 1: a mole retreated unhit this cycle.
- `score` out SCORE_W: current round score.
- `high_score` out SCORE_W: best completed-round score.
- `streak` out STREAK_W: consecutive hit cycles.
- `mult` out MULT_W: current multiplier, 1..MAX_MULT.
- `new_high` out 1: one-cycle pulse when high_score is raised.
- `game_over` out 1: high in OVER.
- `score_bcd` out 4*BCD_DIGITS: present only with `SCORE_BCD_EN`.
- `bcd_valid` out 1: present only with `SCORE_BCD_EN`.

## Operation
- FSM states: IDLE, PLAY, CHECK, OVER.
  - Reset places the FSM in IDLE.
  - IDLE or OVER with `start` → PLAY. The same edge clears score and streak and sets mult=1.
  - PLAY with `time_up` → CHECK.
  - CHECK → OVER unconditionally.
  - `start` in PLAY or CHECK is ignored.
- Scoring is active in PLAY only. Hits and misses are ignored in every other state.
- Hit cycle: any bit of `whacked` set.
  - pts = popcount(whacked) × mult, where mult is the registered value before this edge.
  - score ← min(score + pts, 2^SCORE_W−1).
  - streak ← min(streak+1, 2^STREAK_W−1).
- Miss cycle:
  - score ← max(score − MISS_PENALTY, 0).
  - streak ← 0.
- Hit and miss in the same cycle: apply the saturated add first, then the floored subtract. streak ← 0, so the miss wins for streak.
- Multiplier: mult = min(1 + streak/STREAK_STEP, MAX_MULT), registered from the post-update streak.
- CHECK cycle: if score > high_score, then high_score ← score and new_high ← 1. Equal scores do not update.
- `time_up` together with hits/miss in PLAY: that cycle's events are applied, then the comparison in CHECK uses the committed score.
- Score holds through CHECK, OVER and IDLE until the next `start`.
- Arithmetic: products and sums are computed at SCORE_W+MULT_W+clog2(N_HOLES)+1 bits and then clamped. There is no wrap-around anywhere.

## Timing
- Reset values:
  - score = 0, high_score = 0, streak = 0, mult = 1.
  - new_high = 0, game_over = 0.
  - score_bcd = 0, bcd_valid = 1.
- Events sampled at edge t are visible on `score`, `streak` and `mult` after edge t, i.e. 1-cycle latency.
- `time_up` at edge t:
  - CHECK after t.
  - OVER after t+1, with high_score updated and new_high=1.
  - new_high=0 after t+2.
- `start` at edge t: PLAY and score=0 after t. Hits at edge t+1 are counted.
- `reset` low mid-round: all outputs return to reset values at the next edge. Reset wins over every other input.

## Configuration
- Macro: `SCORE_BCD_EN`.
- Defined:
  - A sequential double-dabble converter drives `score_bcd`.
  - Any change of `score` (re)starts a conversion. A change during a conversion aborts and restarts it.
  - `bcd_valid` drops on the edge after the change and returns high SCORE_W+1 cycles after the last change, with `score_bcd` then equal to BCD(score).
  - Converting a value larger than 10^BCD_DIGITS−1 yields the truncated low digits.
- Undefined: `score_bcd`, `bcd_valid` and the converter do not exist. All other behaviour is identical.

## Structure
- Shared package `score_pkg`:
  - FSM state enum.
  - `MULT_W = $clog2(MAX_MULT+1)` helper function.
  - `popcount` function.
  - Saturating add and floored subtract functions.
- One sub-module, `score_bcd_conv` (shift-add-3 BCD converter), instantiated only under `SCORE_BCD_EN`. All other logic stays in `score_tracker`.

## Test plan
All scenarios use default parameters.
- Reset low 1 cycle, then start; whacked=9'b000000001 for 4 cycles → score 1,2,3,4; mult=2 after 4th hit; 5th hit → score 6.
- whacked=9'b000000111 in one cycle with mult=1 → score +3, streak +1.
- score=0, miss → score stays 0, streak=0. score=5, hit and miss in the same cycle with mult=2 → score 6, streak 0.
- Force score near 16'hFFFF and hit with mult=4 → score=16'hFFFF, no wrap.
- Round 1 ends at 10 → high_score=10, new_high pulses exactly 1 cycle. Round 2 ends at 10 → no update, no pulse. Round 3 ends at 12 → 12.
- With `SCORE_BCD_EN`: score 1234 → bcd_valid low, then high after 17 cycles with score_bcd=20'h01234. reset low in PLAY → all outputs at reset values after the next edge.
